systolic_array: RTL and testbench
=================================

# systolic_array

DIM×DIM output-stationary systolic multiply-accumulate grid, directly downstream of the skewed operand memories `memA` and `memB`. Each cycle it takes one skewed column of A (left edge) and one skewed row of B (top edge), shifts operands one PE per cycle, and accumulates C = A×B in place. C rows are preloadable and readable one row at a time. A pass counter flags when a full 3·DIM−2 cycle product has completed.

## Interface
- `BITS_AB`, 8: signed operand width.
- `BITS_C`, 16: signed accumulator width.
- `DIM`, 8: array dimension.
- `ROWBITS`, $clog2(DIM): row-select width.

- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high; one clock.
- `en` input 1: advance the array one step (shift operands, accumulate).
- `WrEn` input 1: write `Cin` into accumulator row `Crow`.
- `Crow` input ROWBITS: row select for C write and C read.
- `Ain[DIM]` input signed BITS_AB: left-edge A operands; `Ain[r]` enters row r. Driven from `memA.Aout`.
- `Bin[DIM]` input signed BITS_AB: top-edge B operands; `Bin[c]` enters column c. Driven from `memB.Bout`.
- `Cin[DIM]` input signed BITS_C: preload data for row `Crow`.
- `Cout[DIM]` output signed BITS_C: accumulators of row `Crow`, combinational read.
- `Aout[DIM]` output signed BITS_AB: A leaving the right edge, row r.
- `Bout[DIM]` output signed BITS_AB: B leaving the bottom edge, column c.
- `done` output 1: one-cycle pulse when a full pass completes.

## Operation
- PE(r,c) holds registers a, b, acc. A input is `Ain[r]` for c=0, else PE(r,c−1).a. B input is `Bin[c]` for r=0, else PE(r−1,c).b.
- When `en`: a, b load the inputs, and acc ← acc + sext(a_in × b_in).
- The product is a signed BITS_AB×BITS_AB → 2·BITS_AB result, sign-extended to BITS_C. The sum wraps mod 2^BITS_C.
- When `WrEn`: acc of every PE in row `Crow` ← `Cin[c]`.
  - This write overrides accumulation in that row in the same cycle.
  - a and b in that row still shift if `en` is high.
  - Other rows behave normally.
- `Cout[c]` = PE(`Crow`,c).acc. `Aout[r]` = PE(r,DIM−1).a. `Bout[c]` = PE(DIM−1,c).b.
- Pass counter `cnt`, range 0..3·DIM−2:
  - Increments on each `en` cycle.
  - When an `en` cycle occurs with `cnt` = 3·DIM−3, `done` ← 1 next cycle and `cnt` ← 0.
  - Any `WrEn` cycle clears `cnt` to 0 and suppresses `done`. Clear wins over increment.
- `en` low: all registers and `cnt` hold.
- Reset values: all a, b, acc = 0; `cnt` = 0; `done` = 0. Therefore `Cout`, `Aout` and `Bout` are all 0 after reset.
- Reset mid-pass discards partial sums and the counter.

## Timing
- Operand hop latency is 1 enabled cycle per PE. `Ain[r]` appears on `Aout[r]` DIM enabled cycles later, and likewise `Bin` to `Bout`.
- Full product needs 3·DIM−2 enabled cycles (22 for DIM=8), matching the memA/memB drain length.
- `done` is high for exactly one cycle after the last enabled cycle of the pass.
- `Cout` changes the same cycle `Crow` changes, since the read is combinational.
- `Cout` shows updated acc the cycle after the `en` or `WrEn` edge.

## Configuration
- `SYSARR_SAT_EN` defined: accumulation saturates to [−2^(BITS_C−1), 2^(BITS_C−1)−1] per PE per cycle.
- `SYSARR_SAT_EN` undefined: two's-complement wrap.
- `WrEn` preload values are stored unmodified in both modes.

## Structure
- Shared package `tpu_pkg`:
  - `BITS_AB`, `BITS_C`, `DIM`, `ROWBITS` defaults.
  - typedefs `ab_t` (signed BITS_AB) and `c_t` (signed BITS_C).
  - constant `PASS_CYCLES` = 3·DIM−2.
- One sub-module `tpumac`: a single PE with en/WrEn/Cin, a, b, acc, and the saturation option. It is instantiated DIM×DIM via generate.

## Test plan
- Reset: hold `rst` for 2 cycles → all `Cout`, `Aout`, `Bout` = 0, `done` = 0 for every `Crow`.
- Identity: A = I and B[k][c] = c+1, fed skewed from memA/memB for 22 `en` cycles → every row reads 1,2,…,8. `done` pulses once, in cycle 23.
- Preload: `WrEn`, `Crow`=3, `Cin` all 100; then A = I, B all 1 for 22 cycles → row 3 reads 101 everywhere, other rows read 1.
- Overflow: A and B all 127, 22 cycles → each acc = −2040 (129032 wrapped). With `SYSARR_SAT_EN` → 32767.
- Stall: `en` dropped for 3 cycles at cycle 10 of the identity test → identical final C, `done` 3 cycles later, outputs frozen during the stall.
- Reset mid-pass: `rst` at cycle 10 → all acc 0 next cycle. No `done` until a fresh 22-cycle pass completes.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared sizing and operand/accumulator types for the systolic MAC array.
package tpu_pkg;

    localparam int unsigned BITS_AB     = 8;
    localparam int unsigned BITS_C      = 16;
    localparam int unsigned DIM         = 8;
    localparam int unsigned ROWBITS     = $clog2(DIM);
    localparam int unsigned PASS_CYCLES = 3 * DIM - 2;

    typedef logic signed [BITS_AB-1:0] ab_t;
    typedef logic signed [BITS_C-1:0]  c_t;

endpackage

// File: rtl/tpumac.sv
// Single processing element: operand pass-through registers plus a signed MAC accumulator.
// Build option SYSARR_SAT_EN: saturating accumulation instead of two's-complement wrap.
module tpumac #(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned BITS_C  = tpu_pkg::BITS_C
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_en,
    input  logic signed [BITS_AB-1:0] ain,
    input  logic signed [BITS_AB-1:0] bin,
    input  logic signed [BITS_C-1:0]  cin,
    output logic signed [BITS_AB-1:0] a,
    output logic signed [BITS_AB-1:0] b,
    output logic signed [BITS_C-1:0]  acc
);

    localparam int unsigned PW = 2 * BITS_AB;
    localparam int unsigned SW = BITS_C + 1;

    logic signed [PW-1:0]     prod;
    logic signed [BITS_C-1:0] prod_x;
    logic signed [BITS_C-1:0] acc_next;
`ifdef SYSARR_SAT_EN
    logic signed [SW-1:0]     sum;
`endif

    // Full-precision product, sign-extended into the accumulator width.
    always_comb begin
        prod     = PW'(ain) * PW'(bin);
        prod_x   = BITS_C'(prod);
        acc_next = acc + prod_x;
`ifdef SYSARR_SAT_EN
        sum = SW'(acc) + SW'(prod_x);
        if (sum[SW-1] != sum[SW-2]) begin
            acc_next = sum[SW-1] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
        end else begin
            acc_next = sum[BITS_C-1:0];
        end
`endif
    end

    // Preload takes priority over accumulation; operands still shift with en.
    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            acc <= '0;
        end else begin
            if (en) begin
                a <= ain;
                b <= bin;
            end
            if (wr_en) begin
                acc <= cin;
            end else if (en) begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic MAC grid with row preload/readback and pass-complete pulse.
// Build option SYSARR_SAT_EN (passed to every tpumac): saturating accumulation.
module systolic_array #(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned BITS_C  = tpu_pkg::BITS_C,
    parameter int unsigned DIM     = tpu_pkg::DIM,
    parameter int unsigned ROWBITS = $clog2(DIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic [ROWBITS-1:0]        Crow,
    input  logic signed [BITS_AB-1:0] Ain  [DIM],
    input  logic signed [BITS_AB-1:0] Bin  [DIM],
    input  logic signed [BITS_C-1:0]  Cin  [DIM],
    output logic signed [BITS_C-1:0]  Cout [DIM],
    output logic signed [BITS_AB-1:0] Aout [DIM],
    output logic signed [BITS_AB-1:0] Bout [DIM],
    output logic                      done
);

    localparam int unsigned PASS = 3 * DIM - 2;
    localparam int unsigned CW   = $clog2(PASS + 1);

    logic signed [BITS_AB-1:0] a_q   [DIM][DIM];
    logic signed [BITS_AB-1:0] b_q   [DIM][DIM];
    logic signed [BITS_C-1:0]  acc_q [DIM][DIM];
    logic [CW-1:0]             cnt;

    // A flows left to right along rows, B top to bottom along columns.
    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            logic signed [BITS_AB-1:0] ain_w;
            logic signed [BITS_AB-1:0] bin_w;
            logic                      wr_row;

            if (c == 0) begin : g_aedge
                assign ain_w = Ain[r];
            end else begin : g_ain
                assign ain_w = a_q[r][c-1];
            end
            if (r == 0) begin : g_bedge
                assign bin_w = Bin[c];
            end else begin : g_bin
                assign bin_w = b_q[r-1][c];
            end
            assign wr_row = WrEn && (Crow == ROWBITS'(r));

            tpumac #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .wr_en (wr_row),
                .ain   (ain_w),
                .bin   (bin_w),
                .cin   (Cin[c]),
                .a     (a_q[r][c]),
                .b     (b_q[r][c]),
                .acc   (acc_q[r][c])
            );
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_edge
        assign Cout[i] = acc_q[Crow][i];
        assign Aout[i] = a_q[i][DIM-1];
        assign Bout[i] = b_q[DIM-1][i];
    end

    // Pass counter: a preload restarts the pass and cancels any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (WrEn) begin
                cnt <= '0;
            end else if (en) begin
                if (cnt == CW'(PASS - 1)) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: table-driven matrix passes plus hand-written corner sequences.
module tb_systolic_array;
    import tpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst, en, WrEn;
    logic [ROWBITS-1:0] Crow;
    ab_t                Ain [DIM];
    ab_t                Bin [DIM];
    c_t                 Cin [DIM];
    c_t                 Cout [DIM];
    ab_t                Aout [DIM];
    ab_t                Bout [DIM];
    logic               done;

    always #5 clk = ~clk;

    systolic_array dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .WrEn (WrEn),
        .Crow (Crow),
        .Ain  (Ain),
        .Bin  (Bin),
        .Cin  (Cin),
        .Cout (Cout),
        .Aout (Aout),
        .Bout (Bout),
        .done (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference: matrices, expected accumulators, and edge delay lines (oldest entry = edge output).
    int A  [DIM][DIM];
    int B  [DIM][DIM];
    int cm [DIM][DIM];
    int aq [DIM][$];
    int bq [DIM][$];

    typedef struct {
        string name;
        int    mode;
        int    pre_row;
        int    pre_val;
        int    pr;
        int    pc;
        int    pexp;
        bit    has_exp;
        int    stall_len;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int accum(input int acc, input int p);
        int s;
        c_t t;
        s = acc + p;
`ifdef SYSARR_SAT_EN
        if (s > (1 << (BITS_C - 1)) - 1) s = (1 << (BITS_C - 1)) - 1;
        if (s < -(1 << (BITS_C - 1)))    s = -(1 << (BITS_C - 1));
`endif
        t = c_t'(s);
        return int'(t);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < DIM; i++) begin
            aq[i].delete();
            bq[i].delete();
            for (int j = 0; j < DIM; j++) begin
                aq[i].push_back(0);
                bq[i].push_back(0);
                cm[i][j] = 0;
            end
        end
    endtask

    task automatic shift_model();
        for (int i = 0; i < DIM; i++) begin
            aq[i].push_back(int'(Ain[i]));
            void'(aq[i].pop_front());
            bq[i].push_back(int'(Bin[i]));
            void'(bq[i].pop_front());
        end
    endtask

    task automatic step(input bit e, input bit w, input bit r);
        en   = e;
        WrEn = w;
        rst  = r;
        @(posedge clk);
        #1;
        en   = 1'b0;
        WrEn = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic check_pipe(input string tag);
        for (int i = 0; i < DIM; i++) begin
            chk({tag, "_aout"}, int'(Aout[i]), aq[i][0]);
            chk({tag, "_bout"}, int'(Bout[i]), bq[i][0]);
        end
    endtask

    // Walks every row through the combinational read port; stays within one clock period.
    task automatic check_c(input string tag);
        for (int r = 0; r < DIM; r++) begin
            Crow = ROWBITS'(r);
            #1;
            for (int c = 0; c < DIM; c++) chk({tag, "_cout"}, int'(Cout[c]), cm[r][c]);
        end
    endtask

    task automatic set_skew(input int t);
        for (int i = 0; i < DIM; i++) begin
            Ain[i] = (t - i >= 0 && t - i < DIM) ? ab_t'(A[i][t - i]) : ab_t'(0);
            Bin[i] = (t - i >= 0 && t - i < DIM) ? ab_t'(B[t - i][i]) : ab_t'(0);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                case (mode)
                    0: begin A[i][j] = (i == j) ? 1 : 0; B[i][j] = j + 1; end
                    1: begin A[i][j] = (i == j) ? 1 : 0; B[i][j] = 1; end
                    2: begin A[i][j] = 127; B[i][j] = 127; end
                    default: begin
                        A[i][j] = int'($urandom_range(0, 255)) - 128;
                        B[i][j] = int'($urandom_range(0, 255)) - 128;
                    end
                endcase
            end
        end
    endtask

    task automatic compute_c();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                for (int k = 0; k < DIM; k++)
                    cm[r][c] = accum(cm[r][c], A[r][k] * B[k][c]);
    endtask

    // Clears every accumulator (and the pass counter), then optionally preloads one row.
    task automatic preload(input int pre_row, input int pre_val);
        for (int r = 0; r < DIM; r++) begin
            Crow = ROWBITS'(r);
            for (int c = 0; c < DIM; c++) begin
                Cin[c]   = (r == pre_row) ? c_t'(pre_val) : c_t'(0);
                cm[r][c] = (r == pre_row) ? pre_val : 0;
            end
            step(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic run_pass(input string tag, input int stall_len);
        int   cyc;
        int   done_cnt;
        int   done_at;
        c_t   snap;
        cyc      = 0;
        done_cnt = 0;
        done_at  = -1;
        Crow     = ROWBITS'(0);
        for (int t = 0; t < PASS_CYCLES; t++) begin
            if (t == 10 && stall_len > 0) begin
                snap = Cout[DIM-1];
                for (int s = 0; s < stall_len; s++) begin
                    set_skew(t + 3);
                    step(1'b0, 1'b0, 1'b0);
                    cyc++;
                    if (done) begin done_cnt++; if (done_at < 0) done_at = cyc + 1; end
                    check_pipe({tag, "_stall"});
                    chk({tag, "_stall_cout"}, int'(Cout[DIM-1]), int'(snap));
                end
            end
            set_skew(t);
            shift_model();
            step(1'b1, 1'b0, 1'b0);
            cyc++;
            if (done) begin done_cnt++; if (done_at < 0) done_at = cyc + 1; end
            check_pipe(tag);
        end
        step(1'b0, 1'b0, 1'b0);
        cyc++;
        if (done) done_cnt++;
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_at, PASS_CYCLES + 1 + stall_len);
    endtask

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef SYSARR_SAT_EN
        int ovf_exp = 32767;
`else
        int ovf_exp = -2040;
`endif
        int ain_v;
        int bin_v;

        vecs[0] = '{"identity", 0, -1,   0, 3, 7, 8,       1'b1, 0};
        vecs[1] = '{"preload",  1,  3, 100, 3, 0, 101,     1'b1, 0};
        vecs[2] = '{"overflow", 2, -1,   0, 5, 2, ovf_exp, 1'b1, 0};
        vecs[3] = '{"stall",    0, -1,   0, 6, 5, 6,       1'b1, 3};
        vecs[4] = '{"rand0",    3, -1,   0, 0, 0, 0,       1'b0, 0};
        vecs[5] = '{"rand1",    3,  5, -77, 0, 0, 0,       1'b0, 0};
        vecs[6] = '{"rand2",    3, -1,   0, 0, 0, 0,       1'b0, 2};

        rst  = 1'b1;
        en   = 1'b0;
        WrEn = 1'b0;
        Crow = '0;
        for (int i = 0; i < DIM; i++) begin
            Ain[i] = '0;
            Bin[i] = '0;
            Cin[i] = '0;
        end

        // Reset held for two cycles.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        reset_model();
        chk("reset_done", int'(done), 0);
        check_pipe("reset");
        check_c("reset");

        foreach (vecs[v]) begin
            fill(vecs[v].mode);
            preload(vecs[v].pre_row, vecs[v].pre_val);
            run_pass(vecs[v].name, vecs[v].stall_len);
            compute_c();
            check_c(vecs[v].name);
            if (vecs[v].has_exp) begin
                Crow = ROWBITS'(vecs[v].pr);
                #1;
                chk({vecs[v].name, "_probe"}, int'(Cout[vecs[v].pc]), vecs[v].pexp);
            end
        end

        // Reset in the middle of a pass: sums and counter discarded.
        fill(3);
        preload(-1, 0);
        for (int t = 0; t < 10; t++) begin
            set_skew(t);
            step(1'b1, 1'b0, 1'b0);
            chk("midrst_pre_done", int'(done), 0);
        end
        step(1'b0, 1'b0, 1'b1);
        reset_model();
        chk("midrst_done", int'(done), 0);
        check_c("midrst");
        check_pipe("midrst");
        fill(3);
        run_pass("midrst_fresh", 0);
        compute_c();
        check_c("midrst_fresh");

        // Preload and shift in the same cycle: row 2 takes Cin, other rows accumulate.
        Crow = ROWBITS'(2);
        for (int i = 0; i < DIM; i++) begin
            Ain[i] = ab_t'(int'($urandom_range(0, 255)) - 128);
            Bin[i] = ab_t'(int'($urandom_range(0, 255)) - 128);
            Cin[i] = c_t'(7 + i);
        end
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                ain_v = (c == 0) ? int'(Ain[r]) : aq[r][DIM - c];
                bin_v = (r == 0) ? int'(Bin[c]) : bq[c][DIM - r];
                cm[r][c] = (r == 2) ? 7 + c : accum(cm[r][c], ain_v * bin_v);
            end
        end
        shift_model();
        step(1'b1, 1'b1, 1'b0);
        chk("wr_en_done", int'(done), 0);
        check_pipe("wr_en");
        check_c("wr_en");

        // The preload above restarted the count: done only after a full pass more.
        for (int i = 0; i < DIM; i++) begin
            Ain[i] = '0;
            Bin[i] = '0;
        end
        for (int t = 0; t < PASS_CYCLES - 1; t++) begin
            shift_model();
            step(1'b1, 1'b0, 1'b0);
            chk("restart_no_done", int'(done), 0);
        end
        shift_model();
        step(1'b1, 1'b0, 1'b0);
        chk("restart_done", int'(done), 1);
        check_pipe("restart");
        step(1'b0, 1'b0, 1'b0);
        chk("restart_done_drop", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
